// File: rtl/cic_int_pkg.sv
// Shared width helpers and parameter sanity checks for the transmit-path CIC interpolator.
package cic_int_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int acc_width(input int isz, input int n, input int g);
        return isz + n * g;
    endfunction

    // Integrator DC gain is RATE**(N-1); dropping this many LSBs restores unity.
    function automatic int out_shift(input int n, input int g);
        return (n - 1) * g;
    endfunction

    function automatic bit rate_ok(input int rate, input int g);
        return (rate == (1 << g)) && (clog2(rate) == g);
    endfunction

endpackage

// File: rtl/cic_int_if.sv
// Sample-pacing and output bundle between the CIC interpolator, its upstream source and the DAC side.
interface cic_int_if #(
    parameter int ISZ = 16,
    parameter int OSZ = 16
);
    logic signed [ISZ-1:0] x;
    logic                  x_valid;
    logic                  req;
    logic signed [OSZ-1:0] y;
    logic                  valid;
    logic                  underflow;

    modport master (output x, x_valid, input req, y, valid, underflow);
    modport slave  (input x, x_valid, output req, y, valid, underflow);
endinterface

// File: rtl/cic_int_integrator.sv
// One wrap-around accumulate stage of the full-rate integrator chain.
module cic_int_integrator #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc <= '0;
        else          acc <= acc + din;
    end

endmodule

// File: rtl/cic_int_4.sv
// CIC interpolator: low-rate combs, zero-stuff by RATE, full-rate integrators, unity DC gain.
module cic_int_4
    import cic_int_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int STG_GSZ    = 8,
    parameter int RATE       = 256,
    parameter int ISZ        = 16,
    parameter int OSZ        = ISZ
) (
    input  logic      clk,
    input  logic      reset_n,
    cic_int_if.slave  bus
);

    localparam int ASZ = acc_width(ISZ, NUM_STAGES, STG_GSZ);
    localparam int SH  = out_shift(NUM_STAGES, STG_GSZ);
    localparam int N   = NUM_STAGES;

    if (!rate_ok(RATE, STG_GSZ)) begin : g_bad_rate
        $error("cic_int_4: RATE must equal 2**STG_GSZ");
    end

    logic [STG_GSZ-1:0]        count;
    logic                      req;
    logic [ASZ-1:0]            x_ext;
    logic [N:0][ASZ-1:0]       comb_diff;
    logic [N-1:0][ASZ-1:0]     comb_dly;
    logic [N:0]                comb_ena;
    logic [ASZ-1:0]            u;
    logic [N-1:0][ASZ-1:0]     integ;
    logic [N-1:0][ASZ-1:0]     integ_in;
    logic [2*N:0]              pend;
    logic [OSZ-1:0]            y_q;
    logic                      valid_q;
    logic                      underflow_q;
    logic                      unused_bits;

    assign req   = (count == STG_GSZ'(RATE - 1));
    assign x_ext = {{(ASZ-ISZ){bus.x[ISZ-1]}}, bus.x};
    assign u     = comb_ena[N] ? comb_diff[N] : '0;

    assign bus.req       = req;
    assign bus.y         = y_q;
    assign bus.valid     = valid_q;
    assign bus.underflow = underflow_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= '0;
            comb_diff   <= '0;
            comb_dly    <= '0;
            comb_ena    <= '0;
            pend        <= '0;
            y_q         <= '0;
            valid_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count    <= count + 1'b1;
            comb_ena <= {comb_ena[N-1:0], req};
            // Tracks an accepted sample down the 2N+1 clk pipe so valid rises with its first y.
            pend     <= {pend[2*N-1:0], req & bus.x_valid};

            if (req) begin
                comb_diff[0] <= bus.x_valid ? x_ext : '0;
                comb_dly[0]  <= comb_diff[0];
                if (!bus.x_valid) underflow_q <= 1'b1;
            end

            for (int j = 1; j <= N; j++) begin
                if (comb_ena[j-1]) comb_diff[j] <= comb_diff[j-1] - comb_dly[j-1];
            end
            for (int j = 1; j < N; j++) begin
                if (comb_ena[j-1]) comb_dly[j] <= comb_diff[j];
            end

            if (pend[2*N]) valid_q <= 1'b1;
            y_q <= integ[N-1][SH+OSZ-1:SH];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_integ
        if (i == 0) begin : g_head
            assign integ_in[i] = u;
        end else begin : g_tail
            assign integ_in[i] = integ[i-1];
        end
        cic_int_integrator #(.W(ASZ)) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (integ_in[i]),
            .acc     (integ[i])
        );
    end

    // Bits outside the output window carry no information once the final result fits.
    assign unused_bits = ^{integ[N-1][ASZ-1:SH+OSZ], integ[N-1][SH-1:0]};

endmodule

// File: tb/tb_cic_int_4.sv
// Bench for cic_int_4: default build (RATE=256) plus a small build (RATE=4, ISZ=8) for impulse checks.
module tb_cic_int_4;

    localparam int RATE   = 256;
    localparam int NST    = 4;
    localparam int RATE_I = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cic_int_if #(.ISZ(16), .OSZ(16)) bus ();
    cic_int_if #(.ISZ(8),  .OSZ(8))  ibus ();

    cic_int_4 #(.NUM_STAGES(4), .STG_GSZ(8), .RATE(256), .ISZ(16), .OSZ(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    cic_int_4 #(.NUM_STAGES(4), .STG_GSZ(2), .RATE(4), .ISZ(8), .OSZ(8)) dut_imp (
        .clk(clk), .reset_n(reset_n), .bus(ibus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic signed [7:0] y;
        logic              valid;
    } imp_t;

    logic signed [15:0] dc_q[$];
    imp_t               imp_q[$];

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        bus.x = 16'sd0;  bus.x_valid = 1'b1;
        ibus.x = 8'sd0;  ibus.x_valid = 1'b1;
        do_reset();
        checks++; if (bus.y !== 16'sd0)     begin errors++; $display("FAIL reset_y got %0d expected 0", bus.y); end
        checks++; if (bus.req !== 1'b0)     begin errors++; $display("FAIL reset_req got %b expected 0", bus.req); end
        checks++; if (bus.valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b expected 0", bus.valid); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b expected 0", bus.underflow); end
        checks++; if (ibus.y !== 8'sd0)     begin errors++; $display("FAIL reset_imp_y got %0d expected 0", ibus.y); end
    endtask

    task automatic test_pacing();
        int n_req = 0, n_ireq = 0, doubles = 0;
        logic prev = 1'b0;
        for (int i = 0; i < 10 * RATE; i++) begin
            @(negedge clk);
            if (bus.req) begin
                n_req++;
                if (prev) doubles++;
            end
            if (ibus.req) n_ireq++;
            prev = bus.req;
        end
        checks++; if (n_req != 10) begin errors++; $display("FAIL pacing_count got %0d expected 10", n_req); end
        checks++; if (doubles != 0) begin errors++; $display("FAIL pacing_width got %0d wide pulses expected 0", doubles); end
        checks++; if (n_ireq != 10 * RATE / RATE_I) begin errors++; $display("FAIL pacing_imp_count got %0d expected %0d", n_ireq, 10 * RATE / RATE_I); end
    endtask

    // Constant 1000 with x/x_valid scrambled on non-req cycles, which must be ignored.
    task automatic test_dc();
        logic signed [15:0] e;
        int bad = 0;
        bus.x = 16'sd1000; bus.x_valid = 1'b1;
        repeat (8 * RATE) @(negedge clk);
        for (int i = 0; i < 2 * RATE; i++) begin
            @(negedge clk);
            if (dc_q.size() > 0) begin
                e = dc_q.pop_front();
                checks++;
                if (bus.y !== e) begin
                    errors++; bad++;
                    if (bad < 5) $display("FAIL dc_y got %0d expected %0d", bus.y, e);
                end
            end
            if (bus.req) begin
                bus.x = 16'sd1000; bus.x_valid = 1'b1;
            end else begin
                bus.x = 16'($urandom); bus.x_valid = 1'($urandom_range(0, 1));
            end
            dc_q.push_back(16'sd1000);
        end
        dc_q.delete();
        bus.x = 16'sd1000; bus.x_valid = 1'b1;
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL dc_valid got %b expected 1", bus.valid); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL dc_underflow got %b expected 0", bus.underflow); end
    endtask

    task automatic test_underflow();
        int found = 0, min_y = 32767, valid_drops = 0;
        for (int i = 0; i < 2 * RATE && found == 0; i++) begin
            @(negedge clk);
            if (bus.req) found = 1;
        end
        checks++; if (found == 0) begin errors++; $display("FAIL underflow_req_timeout got none expected req"); end
        bus.x_valid = 1'b0;
        @(negedge clk);
        bus.x_valid = 1'b1;
        checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL underflow_set got %b expected 1", bus.underflow); end
        for (int i = 0; i < 4 * RATE; i++) begin
            @(negedge clk);
            if (int'(bus.y) < min_y) min_y = int'(bus.y);
            if (bus.valid !== 1'b1) valid_drops++;
        end
        checks++; if (!(min_y < 1000)) begin errors++; $display("FAIL underflow_dip got min %0d expected below 1000", min_y); end
        checks++; if (valid_drops != 0) begin errors++; $display("FAIL underflow_valid got %0d drops expected 0", valid_drops); end
        repeat (8 * RATE) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (bus.y !== 16'sd1000) begin errors++; $display("FAIL underflow_recover got %0d expected 1000", bus.y); end
        end
        checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky got %b expected 1", bus.underflow); end
    endtask

    task automatic test_negative_full_scale();
        bus.x = -16'sd32768; bus.x_valid = 1'b1;
        repeat (8 * RATE) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (bus.y !== -16'sd32768) begin errors++; $display("FAIL negfs_y got %0d expected -32768", bus.y); end
        end
    endtask

    task automatic test_reset_mid();
        int k = -1;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.y !== 16'sd0)       begin errors++; $display("FAIL midreset_y got %0d expected 0", bus.y); end
        checks++; if (bus.req !== 1'b0)       begin errors++; $display("FAIL midreset_req got %b expected 0", bus.req); end
        checks++; if (bus.valid !== 1'b0)     begin errors++; $display("FAIL midreset_valid got %b expected 0", bus.valid); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL midreset_underflow got %b expected 0", bus.underflow); end
        @(posedge clk);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 2 * RATE && k < 0; i++) begin
            @(negedge clk);
            if (bus.req) k = i;
        end
        checks++; if (k + 1 != RATE) begin errors++; $display("FAIL midreset_first_req got capture at edge %0d expected %0d", k + 1, RATE); end
    endtask

    // Small build: three back-to-back underflows, then an impulse of 64 checked against the
    // box-filter model (1+z+..+z^(R-1))^N scaled by 64 / R^(N-1).
    task automatic test_back_to_back_and_impulse();
        int h[13], t[13];
        int len, found, sum_y, first_nz;
        imp_t e;
        ibus.x = 8'sd64; ibus.x_valid = 1'b0;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            found = 0;
            for (int i = 0; i < 2 * RATE_I && found == 0; i++) begin
                @(negedge clk);
                if (ibus.req) found = 1;
            end
            @(negedge clk);
            checks++; if (found == 0 || ibus.underflow !== 1'b1) begin errors++; $display("FAIL b2b_underflow got %b expected 1", ibus.underflow); end
            checks++; if (ibus.valid !== 1'b0) begin errors++; $display("FAIL b2b_valid got %b expected 0", ibus.valid); end
            checks++; if (ibus.y !== 8'sd0) begin errors++; $display("FAIL b2b_y got %0d expected 0", ibus.y); end
        end

        for (int i = 0; i < 13; i++) h[i] = 0;
        h[0] = 1; len = 1;
        for (int s = 0; s < NST; s++) begin
            for (int i = 0; i < 13; i++) t[i] = 0;
            for (int i = 0; i < len; i++)
                for (int d = 0; d < RATE_I; d++) t[i + d] += h[i];
            len = len + RATE_I - 1;
            for (int i = 0; i < 13; i++) h[i] = t[i];
        end

        found = 0;
        for (int i = 0; i < 2 * RATE_I && found == 0; i++) begin
            @(negedge clk);
            if (ibus.req) found = 1;
        end
        checks++; if (found == 0) begin errors++; $display("FAIL impulse_req_timeout got none expected req"); end
        ibus.x = 8'sd64; ibus.x_valid = 1'b1;
        for (int k = 0; k < 25; k++) begin
            e.y     = (k >= 9 && k < 22) ? 8'((64 * h[k-9]) >>> 6) : 8'sd0;
            e.valid = (k >= 9);
            imp_q.push_back(e);
        end
        sum_y = 0; first_nz = -1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (k == 0) ibus.x = 8'sd0;
            e = imp_q.pop_front();
            sum_y += int'(ibus.y);
            if (first_nz < 0 && ibus.y !== 8'sd0) first_nz = k;
            checks++; if (ibus.y !== e.y) begin errors++; $display("FAIL impulse_y[%0d] got %0d expected %0d", k, ibus.y, e.y); end
            checks++; if (ibus.valid !== e.valid) begin errors++; $display("FAIL impulse_valid[%0d] got %b expected %b", k, ibus.valid, e.valid); end
        end
        checks++; if (first_nz != 9) begin errors++; $display("FAIL impulse_latency got %0d expected 9", first_nz); end
        checks++; if (sum_y != 256) begin errors++; $display("FAIL impulse_sum got %0d expected 256", sum_y); end
    endtask

    initial begin
        test_reset();
        test_pacing();
        test_dc();
        test_underflow();
        test_negative_full_scale();
        test_reset_mid();
        test_back_to_back_and_impulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
